// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, helpers and default geometry for the line memory
package dmem_pkg;

  typedef enum logic {
    DMEM_IDLE = 1'b0,
    DMEM_BUSY = 1'b1
  } dmem_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int line_bytes(input int line_bits);
    return line_bits / 8;
  endfunction

  function automatic int off_bits(input int line_bits);
    return clog2(line_bits / 8);
  endfunction

  localparam int DEF_LINE_BITS  = 256;
  localparam int DEF_LINE_BYTES = line_bytes(DEF_LINE_BITS);
  localparam int DEF_OFF_BITS   = off_bits(DEF_LINE_BITS);

endpackage

// File: rtl/dmem_line_array.sv
// rtl/dmem_line_array.sv - DEPTH x LINE_BITS RAM, registered read port, byte-masked write port
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int LINE_BITS = 256,
  parameter int DEPTH     = 512,
  parameter int IDX_BITS  = clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rd_en,
  input  logic [IDX_BITS-1:0]    rd_idx,
  output logic [LINE_BITS-1:0]   rd_data,
  input  logic                   wr_en,
  input  logic [IDX_BITS-1:0]    wr_idx,
  input  logic [LINE_BITS-1:0]   wr_data,
  input  logic [LINE_BITS/8-1:0] wr_be
);

  logic [LINE_BITS-1:0] mem [DEPTH];

  // array contents deliberately survive reset
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < LINE_BITS / 8; b++) begin
        if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/dmem_line_ctrl.sv
// rtl/dmem_line_ctrl.sv - multi-cycle line memory controller; DMEM_BYTE_MASK_EN adds be_i
module dmem_line_ctrl
  import dmem_pkg::*;
#(
  parameter int LINE_BITS = 256,
  parameter int DEPTH     = 512,
  parameter int ADDR_BITS = 32,
  parameter int READ_LAT  = 10,
  parameter int WRITE_LAT = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [ADDR_BITS-1:0]   addr_i,
  input  logic [LINE_BITS-1:0]   data_i,
`ifdef DMEM_BYTE_MASK_EN
  input  logic [LINE_BITS/8-1:0] be_i,
`endif
  input  logic                   enable_i,
  input  logic                   write_i,
  output logic                   busy_o,
  output logic                   ack_o,
  output logic [LINE_BITS-1:0]   data_o
);

  localparam int OFF_BITS = off_bits(LINE_BITS);
  localparam int IDX_BITS = clog2(DEPTH);
  localparam int MAX_LAT  = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_BITS = clog2(MAX_LAT);

  localparam logic [CNT_BITS-1:0] RD_LAST  = CNT_BITS'(READ_LAT - 1);
  localparam logic [CNT_BITS-1:0] WR_LAST  = CNT_BITS'(WRITE_LAT - 1);
  localparam logic [CNT_BITS-1:0] RD_ISSUE = CNT_BITS'(READ_LAT - 2);

  dmem_state_e           state, state_nxt;
  logic [CNT_BITS-1:0]   lat_cnt;
  logic [IDX_BITS-1:0]   idx_q;
  logic                  wr_q;
  logic [LINE_BITS-1:0]  data_q;
  logic [LINE_BITS/8-1:0] be_q;
  logic [LINE_BITS/8-1:0] be_in;
  logic                  accept;
  logic                  ack;
  logic                  rd_issue;
  logic                  unused_addr;

`ifdef DMEM_BYTE_MASK_EN
  assign be_in = be_i;
`else
  assign be_in = '1;
`endif

  // only the line-index slice of the address matters
  assign unused_addr = ^addr_i;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ack       = 1'b0;
    rd_issue  = 1'b0;
    case (state)
      DMEM_IDLE: begin
        if (enable_i) begin
          accept    = 1'b1;
          state_nxt = DMEM_BUSY;
        end
      end
      DMEM_BUSY: begin
        // registered RAM read is launched one cycle ahead so data_o lands with ack
        rd_issue = !wr_q && (lat_cnt == RD_ISSUE);
        if (lat_cnt == (wr_q ? WR_LAST : RD_LAST)) begin
          ack       = 1'b1;
          state_nxt = DMEM_IDLE;
        end
      end
      default: state_nxt = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= DMEM_IDLE;
      lat_cnt <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      be_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_cnt <= '0;
        idx_q   <= addr_i[OFF_BITS +: IDX_BITS];
        wr_q    <= write_i;
        data_q  <= data_i;
        be_q    <= be_in;
      end else if (state == DMEM_BUSY) begin
        lat_cnt <= ack ? '0 : lat_cnt + 1'b1;
      end
    end
  end

  assign busy_o = (state == DMEM_BUSY);
  assign ack_o  = ack;

  dmem_line_array #(
    .LINE_BITS (LINE_BITS),
    .DEPTH     (DEPTH),
    .IDX_BITS  (IDX_BITS)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .rd_en   (rd_issue && !rst_i),
    .rd_idx  (idx_q),
    .rd_data (data_o),
    .wr_en   (ack && wr_q && !rst_i),
    .wr_idx  (idx_q),
    .wr_data (data_q),
    .wr_be   (be_q)
  );

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// tb/tb_dmem_line_ctrl.sv - directed bench for dmem_line_ctrl, default and small asymmetric configs
module tb_dmem_line_ctrl;

  logic         clk;
  logic         rst;
  logic         sel;
  logic         enable;
  logic         write;
  logic [31:0]  addr;
  logic [255:0] data;
  logic [31:0]  be;

  logic         busy_a, ack_a, busy_b, ack_b;
  logic [255:0] dout_a, dout_b;
  logic         busy, ack;
  logic [255:0] dout;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] PAT_A5   = {32{8'hA5}};
  localparam logic [255:0] PAT_5A   = {32{8'h5A}};
  localparam logic [255:0] PAT_C3   = {32{8'hC3}};
  localparam logic [255:0] PAT_BEEF = {8{32'hDEAD_BEEF}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign busy = sel ? busy_b : busy_a;
  assign ack  = sel ? ack_b  : ack_a;
  assign dout = sel ? dout_b : dout_a;

  dmem_line_ctrl u_dut_a (
    .clk_i    (clk),
    .rst_i    (rst),
    .addr_i   (addr),
    .data_i   (data),
`ifdef DMEM_BYTE_MASK_EN
    .be_i     (be),
`endif
    .enable_i (enable && !sel),
    .write_i  (write),
    .busy_o   (busy_a),
    .ack_o    (ack_a),
    .data_o   (dout_a)
  );

  dmem_line_ctrl #(
    .DEPTH     (16),
    .READ_LAT  (3),
    .WRITE_LAT (7)
  ) u_dut_b (
    .clk_i    (clk),
    .rst_i    (rst),
    .addr_i   (addr),
    .data_i   (data),
`ifdef DMEM_BYTE_MASK_EN
    .be_i     (be),
`endif
    .enable_i (enable && sel),
    .write_i  (write),
    .busy_o   (busy_b),
    .ack_o    (ack_b),
    .data_o   (dout_b)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // full request: accept in cycle 0, ack exactly in cycle lat, idle in cycle lat+1
  task automatic req(input string tag, input logic wr, input logic [31:0] a,
                     input logic [255:0] d, input logic [31:0] b, input int lat,
                     input logic [255:0] exp_dout);
    @(negedge clk);
    enable = 1'b1; write = wr; addr = a; data = d; be = b;
    chk({tag, "_c0_busy"}, {255'b0, busy}, 256'd0);
    @(posedge clk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) enable = 1'b0;
      chk($sformatf("%s_ack_c%0d", tag, k), {255'b0, ack}, {255'b0, (k == lat)});
      if (k == 1 || k == lat) chk($sformatf("%s_busy_c%0d", tag, k), {255'b0, busy}, 256'd1);
      if (k == lat) chk({tag, "_dout"}, dout, exp_dout);
    end
    @(negedge clk);
    chk({tag, "_idle_ack"}, {255'b0, ack}, 256'd0);
    chk({tag, "_idle_busy"}, {255'b0, busy}, 256'd0);
  endtask

  initial begin
    int ack_cnt;
    sel = 1'b0; rst = 1'b1; enable = 1'b1; write = 1'b0;
    addr = 32'h0; data = '0; be = 32'hFFFF_FFFF;

    // reset held two cycles with enable high
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_ack", {255'b0, ack}, 256'd0);
      chk("rst_busy", {255'b0, busy}, 256'd0);
      chk("rst_dout", dout, 256'd0);
    end
    rst = 1'b0; enable = 1'b0;

    // default config: write then read, offset ignored, index wraps
    req("wr_a5", 1'b1, 32'h0000_0040, PAT_A5, 32'hFFFF_FFFF, 10, 256'd0);
    req("rd_a5", 1'b0, 32'h0000_0040, '0, 32'h0, 10, PAT_A5);
    req("rd_off", 1'b0, 32'h0000_005F, '0, 32'h0, 10, PAT_A5);
    req("rd_wrap", 1'b0, 32'h0000_4040, '0, 32'h0, 10, PAT_A5);

    // inputs churn while busy; held enable launches a read in cycle 11
    @(negedge clk);
    enable = 1'b1; write = 1'b1; addr = 32'h0000_0080; data = PAT_BEEF;
    @(posedge clk);
    ack_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ack) ack_cnt++;
      if (k < 10) begin
        addr  = $urandom;
        data  = ~PAT_BEEF ^ 256'(k);
        write = k[0];
      end else begin
        addr  = 32'h0000_0080;
        write = 1'b0;
      end
    end
    @(negedge clk);
    chk("busy_ign_ack_cnt", 256'(ack_cnt), 256'd1);
    chk("busy_ign_c11_busy", {255'b0, busy}, 256'd0);
    chk("busy_ign_c11_ack", {255'b0, ack}, 256'd0);
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        enable = 1'b0;
        chk("held_en_busy", {255'b0, busy}, 256'd1);
      end
      if (k == 10) begin
        chk("held_en_ack", {255'b0, ack}, 256'd1);
        chk("held_en_dout", dout, PAT_BEEF);
      end
    end

`ifdef DMEM_BYTE_MASK_EN
    req("mask_fill", 1'b1, 32'h0000_00C0, '1, 32'hFFFF_FFFF, 10, PAT_BEEF);
    req("mask_wr", 1'b1, 32'h0000_00C0, '0, 32'h0000_000F, 10, PAT_BEEF);
    req("mask_rd", 1'b0, 32'h0000_00C0, '0, 32'h0, 10, {{224{1'b1}}, 32'h0});
`endif

    // reset during cycle 5 of a write aborts it
    @(negedge clk);
    enable = 1'b1; write = 1'b1; addr = 32'h0000_0040; data = PAT_C3;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      enable = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {255'b0, busy}, 256'd0);
    chk("midrst_dout", dout, 256'd0);
    rst = 1'b0;
    for (int k = 7; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_ack_c%0d", k), {255'b0, ack}, 256'd0);
    end
    req("midrst_rd", 1'b0, 32'h0000_0040, '0, 32'h0, 10, PAT_A5);

    // small config: READ_LAT=3, WRITE_LAT=7, DEPTH=16
    sel = 1'b1;
    @(negedge clk);
    req("sm_wr_wrap", 1'b1, 32'h0000_0200, PAT_5A, 32'hFFFF_FFFF, 7, 256'd0);
    req("sm_rd", 1'b0, 32'h0000_0000, '0, 32'h0, 3, PAT_5A);
    req("sm_wr2", 1'b1, 32'h0000_0020, PAT_C3, 32'hFFFF_FFFF, 7, PAT_5A);
    req("sm_rd2", 1'b0, 32'h0000_0220, '0, 32'h0, 3, PAT_C3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
